threshold_integrator_ctrl: RTL and testbench

- Sequencer and supervisor for one threshold_integrator instance.
- Accepts window/threshold configuration through a valid/ready handshake and validates it.
- Arms the integrator, waits for setup_done with a timeout, then monitors the over-threshold and FIFO error flags.
- On any fault it latches a fault code, raises shutdown_req, and recovers only through a controlled integrator reset sequence.

---
 rtl/thresh_ctrl_pkg.sv | 34 +++
 rtl/thresh_fault_latch.sv | 80 ++++++++
 rtl/threshold_integrator_ctrl.sv | 148 ++++++++++++++
 tb/tb_threshold_integrator_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/thresh_ctrl_pkg.sv
// Shared state encodings, fault codes and the fault priority helper for the
// threshold integrator controller.
package thresh_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARMING    = 3'd1,
      RUNNING   = 3'd2,
      FAULT     = 3'd3,
      RESETTING = 3'd4
   } state_e;

   localparam logic [2:0] FLT_NONE    = 3'd0;
   localparam logic [2:0] FLT_OVER    = 3'd1;
   localparam logic [2:0] FLT_OFLOW   = 3'd2;
   localparam logic [2:0] FLT_UFLOW   = 3'd3;
   localparam logic [2:0] FLT_TIMEOUT = 3'd4;
   localparam logic [2:0] FLT_CFG     = 3'd5;

   localparam logic [31:0] DEFAULT_MIN_WINDOW = 32'd2048;

   // FIFO errors outrank the threshold trip; a setup timeout only matters when nothing else fired
   function automatic logic [2:0] fault_prio(input logic oflow, input logic uflow,
                                             input logic over, input logic tmo);
      logic [2:0] code_s;
      if (oflow)      code_s = FLT_OFLOW;
      else if (uflow) code_s = FLT_UFLOW;
      else if (over)  code_s = FLT_OVER;
      else if (tmo)   code_s = FLT_TIMEOUT;
      else            code_s = FLT_NONE;
      return code_s;
   endfunction

endpackage

// File: rtl/thresh_fault_latch.sv
// First-cause fault capture with shutdown request for the integrator controller.
// Optional saturating fault counter enabled by THRESH_CTRL_FAULT_CNT_EN.
module thresh_fault_latch
   import thresh_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        aresetn,
   input  logic        sample_en,
   input  logic        err_overflow,
   input  logic        err_underflow,
   input  logic        over_threshold,
   input  logic        timeout_hit,
   input  logic        cfg_err,
   input  logic        clear,
   output logic        fault_det,
`ifdef THRESH_CTRL_FAULT_CNT_EN
   output logic [15:0] fault_count,
`endif
   output logic [2:0]  fault_code,
   output logic        shutdown_req
);

   logic [2:0] cause_s;
   logic       capture_s;
   logic [2:0] fault_code_r;
   logic       shutdown_req_r;

   // Select the highest-priority active cause
   always_comb begin
      cause_s = FLT_NONE;
      if (sample_en) begin
         cause_s = fault_prio(err_overflow, err_underflow, over_threshold, timeout_hit);
      end else if (cfg_err) begin
         cause_s = FLT_CFG;
      end else begin
         cause_s = FLT_NONE;
      end
   end

   assign fault_det = (cause_s != FLT_NONE);
   assign capture_s = fault_det && (fault_code_r == FLT_NONE);

   // Latch the first cause and hold it until an explicit clear
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         fault_code_r   <= FLT_NONE;
         shutdown_req_r <= 1'b0;
      end else if (clear) begin
         fault_code_r   <= FLT_NONE;
         shutdown_req_r <= 1'b0;
      end else if (capture_s) begin
         fault_code_r   <= cause_s;
         shutdown_req_r <= 1'b1;
      end else begin
         fault_code_r   <= fault_code_r;
         shutdown_req_r <= shutdown_req_r;
      end
   end

`ifdef THRESH_CTRL_FAULT_CNT_EN
   logic [15:0] fault_count_r;

   // Count FAULT entries, saturating; survives clear_fault
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         fault_count_r <= 16'd0;
      end else if (capture_s && (fault_count_r != 16'hFFFF)) begin
         fault_count_r <= fault_count_r + 16'd1;
      end else begin
         fault_count_r <= fault_count_r;
      end
   end

   assign fault_count = fault_count_r;
`endif

   assign fault_code   = fault_code_r;
   assign shutdown_req = shutdown_req_r;

endmodule

// File: rtl/threshold_integrator_ctrl.sv
// Sequencer/supervisor for one threshold_integrator: config handshake, arming with
// setup timeout, fault supervision and controlled reset. Option: THRESH_CTRL_FAULT_CNT_EN.
module threshold_integrator_ctrl
   import thresh_ctrl_pkg::*;
#(
   parameter int                   TIMEOUT_W     = 24,
   parameter logic [TIMEOUT_W-1:0] SETUP_TIMEOUT = 24'd1000000,
   parameter int                   RESET_CYCLES  = 4,
   parameter logic [31:0]          MIN_WINDOW    = DEFAULT_MIN_WINDOW
)(
   input  logic        clk,
   input  logic        aresetn,
   input  logic [31:0] cfg_window,
   input  logic [14:0] cfg_threshold,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic        arm,
   input  logic        disarm,
   input  logic        clear_fault,
   output logic        integ_resetn,
   output logic        integ_enable,
   output logic [31:0] integ_window,
   output logic [14:0] integ_threshold,
   input  logic        integ_setup_done,
   input  logic        integ_over_threshold,
   input  logic        integ_err_overflow,
   input  logic        integ_err_underflow,
   output logic        running,
   output logic        shutdown_req,
   output logic [2:0]  fault_code,
`ifdef THRESH_CTRL_FAULT_CNT_EN
   output logic [15:0] fault_count,
`endif
   output logic [2:0]  state_out
);

   localparam int                   RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RST_CNT_W-1:0] RST_LAST  = RST_CNT_W'(RESET_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] TMO_LAST  = SETUP_TIMEOUT - TIMEOUT_W'(1);

   state_e                 state_r, state_next_s;
   logic [TIMEOUT_W-1:0]   tmo_cnt_r;
   logic [RST_CNT_W-1:0]   rst_cnt_r;
   logic                   cfg_loaded_r, cfg_ready_r, integ_resetn_r, integ_enable_r, running_r;
   logic [31:0]            integ_window_r;
   logic [14:0]            integ_threshold_r;
   logic                   sample_en_s, timeout_hit_s, cfg_bad_s, arm_go_s, cfg_err_s;
   logic                   clear_s, fault_det_s;

   assign sample_en_s   = (state_r == ARMING) || (state_r == RUNNING);
   assign timeout_hit_s = (state_r == ARMING) && (tmo_cnt_r == TMO_LAST);
   assign cfg_bad_s     = (integ_window_r < MIN_WINDOW) || (integ_threshold_r == 15'd0);
   // arm checks the config already latched, never the one offered this cycle
   assign arm_go_s      = (state_r == IDLE) && arm && !disarm && cfg_loaded_r;
   assign cfg_err_s     = arm_go_s && cfg_bad_s;
   assign clear_s       = (state_r == FAULT) && clear_fault;

   thresh_fault_latch u_fault (
      .clk            (clk),
      .aresetn        (aresetn),
      .sample_en      (sample_en_s),
      .err_overflow   (integ_err_overflow),
      .err_underflow  (integ_err_underflow),
      .over_threshold (integ_over_threshold),
      .timeout_hit    (timeout_hit_s),
      .cfg_err        (cfg_err_s),
      .clear          (clear_s),
      .fault_det      (fault_det_s),
`ifdef THRESH_CTRL_FAULT_CNT_EN
      .fault_count    (fault_count),
`endif
      .fault_code     (fault_code),
      .shutdown_req   (shutdown_req)
   );

   // Next-state decode; faults outrank disarm, disarm outranks setup_done
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (arm_go_s) state_next_s = cfg_bad_s ? FAULT : ARMING;
            else          state_next_s = IDLE;
         end
         ARMING: begin
            if (fault_det_s)           state_next_s = FAULT;
            else if (disarm)           state_next_s = RESETTING;
            else if (integ_setup_done) state_next_s = RUNNING;
            else                       state_next_s = ARMING;
         end
         RUNNING: begin
            if (fault_det_s) state_next_s = FAULT;
            else if (disarm) state_next_s = RESETTING;
            else             state_next_s = RUNNING;
         end
         FAULT: begin
            if (clear_fault) state_next_s = RESETTING;
            else             state_next_s = FAULT;
         end
         RESETTING: begin
            if (rst_cnt_r == RST_LAST) state_next_s = IDLE;
            else                       state_next_s = RESETTING;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State, counters and registered outputs derived from the next state
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_r           <= IDLE;
         tmo_cnt_r         <= '0;
         rst_cnt_r         <= '0;
         cfg_loaded_r      <= 1'b0;
         cfg_ready_r       <= 1'b0;
         integ_resetn_r    <= 1'b0;
         integ_enable_r    <= 1'b0;
         running_r         <= 1'b0;
         integ_window_r    <= 32'd0;
         integ_threshold_r <= 15'd0;
      end else begin
         state_r        <= state_next_s;
         tmo_cnt_r      <= (state_r == ARMING) ? tmo_cnt_r + TIMEOUT_W'(1) : '0;
         rst_cnt_r      <= (state_r == RESETTING) ? rst_cnt_r + RST_CNT_W'(1) : '0;
         cfg_ready_r    <= (state_next_s == IDLE);
         integ_resetn_r <= (state_next_s != RESETTING);
         integ_enable_r <= (state_next_s == ARMING) || (state_next_s == RUNNING);
         running_r      <= (state_next_s == RUNNING);
         if (cfg_ready_r && cfg_valid) begin
            integ_window_r    <= cfg_window;
            integ_threshold_r <= cfg_threshold;
            cfg_loaded_r      <= 1'b1;
         end else begin
            integ_window_r    <= integ_window_r;
            integ_threshold_r <= integ_threshold_r;
            cfg_loaded_r      <= cfg_loaded_r;
         end
      end
   end

   assign cfg_ready       = cfg_ready_r;
   assign integ_resetn    = integ_resetn_r;
   assign integ_enable    = integ_enable_r;
   assign integ_window    = integ_window_r;
   assign integ_threshold = integ_threshold_r;
   assign running         = running_r;
   assign state_out       = state_r;

endmodule

// File: tb/tb_threshold_integrator_ctrl.sv
// Directed self-checking bench for threshold_integrator_ctrl (SETUP_TIMEOUT=50, RESET_CYCLES=4).
module tb_threshold_integrator_ctrl;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [31:0] cfg_window;
   logic [14:0] cfg_threshold;
   logic        cfg_valid, cfg_ready, arm, disarm, clear_fault;
   logic        integ_resetn, integ_enable;
   logic [31:0] integ_window;
   logic [14:0] integ_threshold;
   logic        integ_setup_done, integ_over_threshold, integ_err_overflow, integ_err_underflow;
   logic        running, shutdown_req;
   logic [2:0]  fault_code, state_out;
`ifdef THRESH_CTRL_FAULT_CNT_EN
   logic [15:0] fault_count;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   threshold_integrator_ctrl #(
      .TIMEOUT_W     (24),
      .SETUP_TIMEOUT (24'd50),
      .RESET_CYCLES  (4),
      .MIN_WINDOW    (32'd2048)
   ) dut (
      .clk                  (clk),
      .aresetn              (aresetn),
      .cfg_window           (cfg_window),
      .cfg_threshold        (cfg_threshold),
      .cfg_valid            (cfg_valid),
      .cfg_ready            (cfg_ready),
      .arm                  (arm),
      .disarm               (disarm),
      .clear_fault          (clear_fault),
      .integ_resetn         (integ_resetn),
      .integ_enable         (integ_enable),
      .integ_window         (integ_window),
      .integ_threshold      (integ_threshold),
      .integ_setup_done     (integ_setup_done),
      .integ_over_threshold (integ_over_threshold),
      .integ_err_overflow   (integ_err_overflow),
      .integ_err_underflow  (integ_err_underflow),
      .running              (running),
      .shutdown_req         (shutdown_req),
      .fault_code           (fault_code),
`ifdef THRESH_CTRL_FAULT_CNT_EN
      .fault_count          (fault_count),
`endif
      .state_out            (state_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic recover();
      clear_fault = 1'b1; tick(); clear_fault = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      aresetn = 1'b0; cfg_window = 32'd0; cfg_threshold = 15'd0; cfg_valid = 1'b0;
      arm = 1'b0; disarm = 1'b0; clear_fault = 1'b0; integ_setup_done = 1'b0;
      integ_over_threshold = 1'b0; integ_err_overflow = 1'b0; integ_err_underflow = 1'b0;
      tick(); tick();
      chk("rst_state", 32'(state_out), 32'd0);
      chk("rst_integ_resetn", 32'(integ_resetn), 32'd0);
      chk("rst_integ_enable", 32'(integ_enable), 32'd0);
      chk("rst_window", integ_window, 32'd0);
      chk("rst_shutdown", 32'(shutdown_req), 32'd0);
      chk("rst_fault_code", 32'(fault_code), 32'd0);
      chk("rst_running", 32'(running), 32'd0);

      aresetn = 1'b1; tick();
      chk("idle_integ_resetn", 32'(integ_resetn), 32'd1);
      chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);

      // arm without config is ignored
      arm = 1'b1; tick(); arm = 1'b0;
      chk("arm_unloaded", 32'(state_out), 32'd0);

      // config and arm, setup_done on the 20th ARMING cycle
      cfg_window = 32'd4096; cfg_threshold = 15'd100; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
      chk("cfg_window", integ_window, 32'd4096);
      chk("cfg_threshold", 32'(integ_threshold), 32'd100);
      arm = 1'b1; tick(); arm = 1'b0;
      chk("arming_state", 32'(state_out), 32'd1);
      chk("arming_enable", 32'(integ_enable), 32'd1);
      chk("arming_cfg_ready", 32'(cfg_ready), 32'd0);
      repeat (19) tick();
      chk("arming_hold", 32'(state_out), 32'd1);
      integ_setup_done = 1'b1; tick(); integ_setup_done = 1'b0;
      chk("run_state", 32'(state_out), 32'd2);
      chk("run_running", 32'(running), 32'd1);

      // underflow beats over_threshold; later overflow is ignored
      integ_over_threshold = 1'b1; integ_err_underflow = 1'b1; tick();
      integ_over_threshold = 1'b0; integ_err_underflow = 1'b0;
      chk("flt_state", 32'(state_out), 32'd3);
      chk("flt_code_uflow", 32'(fault_code), 32'd3);
      chk("flt_shutdown", 32'(shutdown_req), 32'd1);
      chk("flt_enable", 32'(integ_enable), 32'd0);
      chk("flt_running", 32'(running), 32'd0);
      integ_err_overflow = 1'b1; tick(); integ_err_overflow = 1'b0;
      chk("flt_first_cause", 32'(fault_code), 32'd3);
      arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
      chk("flt_ignore_arm", 32'(state_out), 32'd3);

      // recovery: integ_resetn low for exactly 4 cycles
      clear_fault = 1'b1; tick(); clear_fault = 1'b0;
      chk("rstg_state", 32'(state_out), 32'd4);
      chk("rstg_resetn_c1", 32'(integ_resetn), 32'd0);
      chk("rstg_code_clr", 32'(fault_code), 32'd0);
      chk("rstg_shutdown_clr", 32'(shutdown_req), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstg_resetn_low", 32'(integ_resetn), 32'd0);
      end
      tick();
      chk("rstg_done_resetn", 32'(integ_resetn), 32'd1);
      chk("rstg_done_idle", 32'(state_out), 32'd0);
      chk("rstg_kept_window", integ_window, 32'd4096);

      // re-arm without new config, then disarm from RUNNING
      arm = 1'b1; tick(); arm = 1'b0;
      chk("rearm_state", 32'(state_out), 32'd1);
      integ_setup_done = 1'b1; tick(); integ_setup_done = 1'b0;
      chk("rearm_run", 32'(state_out), 32'd2);
      disarm = 1'b1; tick(); disarm = 1'b0;
      chk("disarm_state", 32'(state_out), 32'd4);
      chk("disarm_code", 32'(fault_code), 32'd0);
      chk("disarm_shutdown", 32'(shutdown_req), 32'd0);
      chk("disarm_enable", 32'(integ_enable), 32'd0);
      repeat (4) tick();
      chk("disarm_idle", 32'(state_out), 32'd0);

      // bad config (window below minimum)
      cfg_window = 32'd1000; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
      arm = 1'b1; tick(); arm = 1'b0;
      chk("badcfg_state", 32'(state_out), 32'd3);
      chk("badcfg_code", 32'(fault_code), 32'd5);
      chk("badcfg_shutdown", 32'(shutdown_req), 32'd1);
      chk("badcfg_enable", 32'(integ_enable), 32'd0);
      recover();
      chk("badcfg_idle", 32'(state_out), 32'd0);

      // cfg_valid with arm: arm uses the old (bad) config, new one is latched
      cfg_window = 32'd4096; cfg_valid = 1'b1; arm = 1'b1; tick(); cfg_valid = 1'b0; arm = 1'b0;
      chk("cfgarm_code", 32'(fault_code), 32'd5);
      chk("cfgarm_window", integ_window, 32'd4096);
      recover();

      // arm with disarm in IDLE: disarm wins
      arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
      chk("armdisarm_idle", 32'(state_out), 32'd0);

      // setup timeout: FAULT decided on ARMING cycle 50
      arm = 1'b1; tick(); arm = 1'b0;
      repeat (49) tick();
      chk("tmo_cycle50_arming", 32'(state_out), 32'd1);
      tick();
      chk("tmo_state", 32'(state_out), 32'd3);
      chk("tmo_code", 32'(fault_code), 32'd4);
      recover();

      // all flags with disarm: fault wins, overflow has top priority
      arm = 1'b1; tick(); arm = 1'b0;
      integ_setup_done = 1'b1; tick(); integ_setup_done = 1'b0;
      integ_err_overflow = 1'b1; integ_err_underflow = 1'b1; integ_over_threshold = 1'b1; disarm = 1'b1;
      tick();
      integ_err_overflow = 1'b0; integ_err_underflow = 1'b0; integ_over_threshold = 1'b0; disarm = 1'b0;
      chk("prio_state", 32'(state_out), 32'd3);
      chk("prio_code_oflow", 32'(fault_code), 32'd2);
`ifdef THRESH_CTRL_FAULT_CNT_EN
      chk("fault_count", 32'(fault_count), 32'd5);
`endif
      recover();

      // aresetn mid-ARMING
      arm = 1'b1; tick(); arm = 1'b0;
      repeat (3) tick();
      aresetn = 1'b0; tick();
      chk("midrst_state", 32'(state_out), 32'd0);
      chk("midrst_resetn", 32'(integ_resetn), 32'd0);
      chk("midrst_enable", 32'(integ_enable), 32'd0);
      chk("midrst_window", integ_window, 32'd0);
      chk("midrst_threshold", 32'(integ_threshold), 32'd0);
      aresetn = 1'b1; tick();
      arm = 1'b1; tick(); arm = 1'b0;
      chk("midrst_cfg_cleared", 32'(state_out), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
